// File: rtl/perf_event_monitor.sv
// Event/cycle counters fed by the CPU debug strobes. Sticky overflow flags,
// a first-exception timestamp, and a one-cycle-latency read port.
module perf_event_monitor #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             count_en,
  input  logic             debug_flush,
  input  logic             debug_is_bj,
  input  logic             debug_exception,
  input  logic             clr,
  input  logic             rd_req,
  input  logic [2:0]       rd_addr,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data
);

  localparam int unsigned NumCnt = 4;

  // Counter slots: 0 CYC, 1 FLUSH, 2 BJ, 3 EXC (same order as the STAT flags).
  logic [CNT_W-1:0]  cnt_q [NumCnt];
  logic [CNT_W-1:0]  cnt_d [NumCnt];
  logic [NumCnt-1:0] ovf_q, ovf_d;
  logic              ts_valid_q, ts_valid_d;
  logic [CNT_W-1:0]  exc_ts_q, exc_ts_d;
  logic              rd_valid_q;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic [NumCnt-1:0] cnt_hit;

  assign cnt_hit = {debug_exception, debug_is_bj, debug_flush, 1'b1};

  always_comb begin
    for (int i = 0; i < NumCnt; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    ovf_d      = ovf_q;
    ts_valid_d = ts_valid_q;
    exc_ts_d   = exc_ts_q;

    if (clr) begin
      for (int i = 0; i < NumCnt; i++) begin
        cnt_d[i] = '0;
      end
      ovf_d      = '0;
      ts_valid_d = 1'b0;
      exc_ts_d   = '0;
    end else if (count_en) begin
      for (int i = 0; i < NumCnt; i++) begin
        if (cnt_hit[i]) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
          if (cnt_q[i] == '1) begin
            ovf_d[i] = 1'b1;
          end
        end
      end
      // Timestamp is the pre-increment cycle count of the first exception only.
      if (debug_exception && !ts_valid_q) begin
        exc_ts_d   = cnt_q[0];
        ts_valid_d = 1'b1;
      end
    end
  end

  // Read mux sees the state before this edge's update: snapshot at request time.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_req) begin
      unique case (rd_addr)
        3'd0:    rd_data_d = cnt_q[0];
        3'd1:    rd_data_d = cnt_q[1];
        3'd2:    rd_data_d = cnt_q[2];
        3'd3:    rd_data_d = cnt_q[3];
        3'd4:    rd_data_d = CNT_W'({ts_valid_q, ovf_q});
        3'd5:    rd_data_d = exc_ts_q;
        default: rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NumCnt; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q      <= '0;
      ts_valid_q <= 1'b0;
      exc_ts_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      for (int i = 0; i < NumCnt; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q      <= ovf_d;
      ts_valid_q <= ts_valid_d;
      exc_ts_q   <= exc_ts_d;
      rd_valid_q <= rd_req;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed bench for perf_event_monitor at CNT_W=8 so wrap behaviour is reachable.
module tb_perf_event_monitor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         count_en;
  logic         debug_flush;
  logic         debug_is_bj;
  logic         debug_exception;
  logic         clr;
  logic         rd_req;
  logic [2:0]   rd_addr;
  logic         rd_valid;
  logic [W-1:0] rd_data;

  int checks   = 0;
  int failures = 0;

  perf_event_monitor #(.CNT_W(W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .count_en        (count_en),
    .debug_flush     (debug_flush),
    .debug_is_bj     (debug_is_bj),
    .debug_exception (debug_exception),
    .clr             (clr),
    .rd_req          (rd_req),
    .rd_addr         (rd_addr),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle read: request sampled at the next edge, result checked just after it.
  task automatic do_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
    rd_req  = 1'b1;
    rd_addr = a;
    step();
    rd_req  = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check(tag, 32'(rd_data), exp);
  endtask

  initial begin
    reset_n = 1'b0;
    count_en = 1'b1;
    debug_flush = 1'b0;
    debug_is_bj = 1'b0;
    debug_exception = 1'b0;
    clr = 1'b0;
    rd_req = 1'b0;
    rd_addr = 3'd0;
    step();
    step();
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);

    // Reset then counting: 10 edges, request sampled at edge 11 returns 10.
    reset_n = 1'b1;
    repeat (10) step();
    check("pre_read_valid", 32'(rd_valid), 32'd0);
    do_read(3'd0, 32'd10, "cyc10");
    step();
    check("idle_valid", 32'(rd_valid), 32'd0);
    check("idle_hold", 32'(rd_data), 32'd10);

    // Event counting.
    clr = 1'b1; step(); clr = 1'b0;
    repeat (3) begin
      debug_flush = 1'b1; step();
      debug_flush = 1'b0; step();
    end
    debug_is_bj = 1'b1;
    repeat (4) step();
    debug_is_bj = 1'b0;
    do_read(3'd1, 32'd3, "flush3");
    do_read(3'd2, 32'd4, "bj4");
    do_read(3'd3, 32'd0, "exc0");
    do_read(3'd4, 32'd0, "stat0");

    // Exception timestamp: exceptions at CYC=25 and CYC=40.
    clr = 1'b1; step(); clr = 1'b0;
    repeat (25) step();
    debug_exception = 1'b1; step(); debug_exception = 1'b0;
    repeat (14) step();
    debug_exception = 1'b1; step(); debug_exception = 1'b0;
    do_read(3'd0, 32'd41, "cyc41");
    do_read(3'd3, 32'd2, "exc2");
    do_read(3'd5, 32'd25, "exc_ts25");
    do_read(3'd4, 32'h10, "stat_ts");
    do_read(3'd6, 32'd0, "addr6");
    do_read(3'd7, 32'd0, "addr7");

    // Overflow: 256 flush strobes; CYC wraps too, setting bit0.
    clr = 1'b1; step(); clr = 1'b0;
    debug_flush = 1'b1;
    repeat (256) step();
    debug_flush = 1'b0;
    do_read(3'd1, 32'd0, "flush_wrap");
    do_read(3'd4, 32'h03, "stat_ovf");
    debug_flush = 1'b1; step(); debug_flush = 1'b0;
    do_read(3'd1, 32'd1, "flush_after_wrap");
    do_read(3'd4, 32'h03, "stat_sticky");

    // Clear priority over a same-cycle event, read returns pre-clear value.
    clr = 1'b1; step(); clr = 1'b0;
    debug_is_bj = 1'b1;
    repeat (7) step();
    debug_is_bj = 1'b0;
    clr = 1'b1;
    debug_is_bj = 1'b1;
    rd_req = 1'b1;
    rd_addr = 3'd2;
    step();
    clr = 1'b0;
    debug_is_bj = 1'b0;
    check("clr_rd_valid", 32'(rd_valid), 32'd1);
    check("clr_rd_old", 32'(rd_data), 32'd7);
    step();
    rd_req = 1'b0;
    check("b2b_valid", 32'(rd_valid), 32'd1);
    check("clr_bj_zero", 32'(rd_data), 32'd0);
    do_read(3'd4, 32'd0, "clr_stat");
    do_read(3'd5, 32'd0, "clr_exc_ts");

    // Freeze: strobes active for 5 cycles with count_en=0.
    clr = 1'b1; step(); clr = 1'b0;
    debug_flush = 1'b1;
    step();
    step();
    count_en = 1'b0;
    debug_is_bj = 1'b1;
    debug_exception = 1'b1;
    repeat (5) step();
    debug_flush = 1'b0;
    debug_is_bj = 1'b0;
    debug_exception = 1'b0;
    do_read(3'd0, 32'd2, "frz_cyc");
    do_read(3'd1, 32'd2, "frz_flush");
    do_read(3'd2, 32'd0, "frz_bj");
    do_read(3'd3, 32'd0, "frz_exc");
    do_read(3'd4, 32'd0, "frz_stat");
    do_read(3'd5, 32'd0, "frz_exc_ts");

    // Asynchronous reset while a read result is being presented.
    rd_req = 1'b1;
    rd_addr = 3'd1;
    step();
    check("pend_valid", 32'(rd_valid), 32'd1);
    check("pend_data", 32'(rd_data), 32'd2);
    reset_n = 1'b0;
    #1;
    check("async_valid", 32'(rd_valid), 32'd0);
    check("async_data", 32'(rd_data), 32'd0);
    rd_req = 1'b0;
    step();
    reset_n = 1'b1;
    do_read(3'd0, 32'd0, "post_rst_cyc");
    do_read(3'd1, 32'd0, "post_rst_flush");
    do_read(3'd2, 32'd0, "post_rst_bj");
    do_read(3'd3, 32'd0, "post_rst_exc");
    do_read(3'd4, 32'd0, "post_rst_stat");
    do_read(3'd5, 32'd0, "post_rst_exc_ts");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
